// File: rtl/beta_operand_stage_if.sv
// ALU-facing result bundle of the Beta decode/operand-fetch stage.
// master: the operand stage that drives the registered operands and sideband.
// slave : the execute stage that consumes them.
interface beta_operand_stage_if;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [3:0]  alufn;
    logic        out_valid;
    logic        out_wen;
    logic [4:0]  out_rc;
    logic        out_is_load;
    logic        out_is_store;
    logic        out_illegal;
    logic [31:0] out_store_data;

    modport master (
        output data_a, data_b, alufn, out_valid, out_wen, out_rc,
               out_is_load, out_is_store, out_illegal, out_store_data
    );
    modport slave (
        input  data_a, data_b, alufn, out_valid, out_wen, out_rc,
               out_is_load, out_is_store, out_illegal, out_store_data
    );
endinterface

// File: rtl/beta_operand_stage.sv
// Beta decode / operand-fetch stage feeding the execute-stage ALU.
// Decodes one instruction per enabled cycle, reads two register-file ports,
// resolves RAW hazards and registers operands plus control sideband.
// Optional feature macro: OPERAND_BYPASS_EN
//   defined   : EX > MEM > WB forwarding, stall only on load-use.
//   undefined : no forwarding, stall on any pending write to a used source.
module beta_operand_stage #(
    parameter int NREG = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic [4:0]  rf_addr_a,
    output logic [4:0]  rf_addr_b,
    input  logic [31:0] rf_data_a,
    input  logic [31:0] rf_data_b,
    input  logic        ex_wen,
    input  logic        mem_wen,
    input  logic        wb_wen,
    input  logic [4:0]  ex_waddr,
    input  logic [4:0]  mem_waddr,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] wb_wdata,
    input  logic        ex_is_load,
    output logic        stall,
    beta_operand_stage_if.master alu
);
    // Highest-numbered register is hardwired to zero.
    localparam logic [4:0] RZERO = 5'(NREG - 1);

    typedef struct packed {
        logic is_op;
        logic is_opc;
        logic is_ld;
        logic is_st;
        logic legal;
    } dec_t;

    logic [5:0]  op;
    logic [4:0]  rc, ra, rb;
    logic [15:0] lit;
    logic [31:0] lit_sext;
    logic        fn_ok;
    dec_t        dec;

    assign op       = in_instr[31:26];
    assign rc       = in_instr[25:21];
    assign ra       = in_instr[20:16];
    assign rb       = in_instr[15:11];
    assign lit      = in_instr[15:0];
    assign lit_sext = {{16{lit[15]}}, lit};

    // Classify the opcode; ALU function codes x7, xB, xF are unassigned.
    always_comb begin
        fn_ok      = !((op[1:0] == 2'b11) && (op[3] || op[2]));
        dec        = '0;
        dec.is_op  = (op[5:4] == 2'b10) && fn_ok;
        dec.is_opc = (op[5:4] == 2'b11) && fn_ok;
        dec.is_ld  = (op == 6'b011000);
        dec.is_st  = (op == 6'b011001);
        dec.legal  = dec.is_op || dec.is_opc || dec.is_ld || dec.is_st;
    end

    // Port B reads the store-data register for ST, rb otherwise.
    assign rf_addr_a = ra;
    assign rf_addr_b = dec.is_st ? rc : rb;

    // Value of source register s, taking in-flight writes into account.
    function automatic logic [31:0] resolve(input logic [4:0] s, input logic [31:0] rf_val);
        logic [31:0] v;
        if (s == RZERO)
            v = '0;
`ifdef OPERAND_BYPASS_EN
        else if (ex_wen && ex_waddr == s)
            v = ex_wdata;
        else if (mem_wen && mem_waddr == s)
            v = mem_wdata;
        else if (wb_wen && wb_waddr == s)
            v = wb_wdata;
`endif
        else
            v = rf_val;
        return v;
    endfunction

    // True when source s cannot be supplied this cycle.
    function automatic logic blocked(input logic [4:0] s);
        logic b;
`ifdef OPERAND_BYPASS_EN
        b = (s != RZERO) && ex_is_load && ex_wen && (ex_waddr == s);
`else
        b = (s != RZERO) && ((ex_wen  && ex_waddr  == s) ||
                             (mem_wen && mem_waddr == s) ||
                             (wb_wen  && wb_waddr  == s));
`endif
        return b;
    endfunction

`ifndef OPERAND_BYPASS_EN
    // Forwarded data and load flag have no consumer without the bypass network.
    logic unused_fwd;
    assign unused_fwd = ^{ex_wdata, mem_wdata, wb_wdata, ex_is_load};
`endif

    logic [31:0] res_a, res_b;
    logic [31:0] nxt_a, nxt_b;
    logic [3:0]  nxt_fn;
    logic        take;

    // Operand muxing; illegal instructions present zero operands.
    always_comb begin
        res_a  = resolve(ra, rf_data_a);
        res_b  = resolve(rf_addr_b, rf_data_b);
        nxt_a  = dec.legal ? res_a : '0;
        nxt_b  = dec.is_op ? res_b : (dec.legal ? lit_sext : '0);
        nxt_fn = (dec.is_op || dec.is_opc) ? op[3:0] : 4'd0;
    end

    // Load-use (or any-pending-write) interlock over the sources actually read.
    assign stall = rst_n && in_valid &&
                   ((dec.legal && blocked(ra)) ||
                    (dec.is_op && blocked(rb)) ||
                    (dec.is_st && blocked(rc)));

    assign take = in_valid && !flush && !stall;

    // Pipeline register: flush/stall/invalid produce a bubble, clk_en=0 holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu.data_a         <= '0;
            alu.data_b         <= '0;
            alu.alufn          <= '0;
            alu.out_valid      <= 1'b0;
            alu.out_wen        <= 1'b0;
            alu.out_rc         <= '0;
            alu.out_is_load    <= 1'b0;
            alu.out_is_store   <= 1'b0;
            alu.out_illegal    <= 1'b0;
            alu.out_store_data <= '0;
        end else if (clk_en) begin
            alu.data_a         <= nxt_a;
            alu.data_b         <= nxt_b;
            alu.alufn          <= nxt_fn;
            alu.out_rc         <= rc;
            alu.out_store_data <= res_b;
            alu.out_valid      <= take;
            alu.out_wen        <= take && dec.legal && !dec.is_st && (rc != RZERO);
            alu.out_is_load    <= take && dec.is_ld;
            alu.out_is_store   <= take && dec.is_st;
            alu.out_illegal    <= take && !dec.legal;
        end
    end
endmodule

// File: tb/tb_beta_operand_stage.sv
// Self-checking bench for beta_operand_stage: directed test-plan cases then
// randomized traffic, checked against an instruction-level reference model.
module tb_beta_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n, clk_en, flush, in_valid;
    logic [31:0] in_instr;
    logic [4:0]  rf_addr_a, rf_addr_b;
    logic [31:0] rf_data_a, rf_data_b;
    logic        ex_wen, mem_wen, wb_wen, ex_is_load;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata;
    logic        stall;
    logic [31:0] rf [32];

    beta_operand_stage_if alu ();

    beta_operand_stage #(.NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .ex_waddr(ex_waddr), .mem_waddr(mem_waddr), .wb_waddr(wb_waddr),
        .ex_wdata(ex_wdata), .mem_wdata(mem_wdata), .wb_wdata(wb_wdata),
        .ex_is_load(ex_is_load), .stall(stall), .alu(alu.master)
    );

    always #5 clk = ~clk;

    // Register file model answering the DUT's read ports.
    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];

    typedef enum {K_OP, K_OPC, K_LD, K_ST, K_ILL} kind_e;
    typedef struct {
        logic        valid, wen, ld, st, ill;
        logic [31:0] a, b, sd;
        logic [3:0]  fn;
        logic [4:0]  rc;
    } exp_t;

    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic kind_e kind_of(input logic [5:0] op);
        int f;
        bit ok;
        f  = int'(op[3:0]);
        ok = f inside {[0:6], [8:10], [12:14]};
        if (op == 6'b011000) return K_LD;
        if (op == 6'b011001) return K_ST;
        if (op[5:4] == 2'b10 && ok) return K_OP;
        if (op[5:4] == 2'b11 && ok) return K_OPC;
        return K_ILL;
    endfunction

    // Architectural value of register s as seen by this instruction.
    function automatic logic [31:0] val(input logic [4:0] s);
        if (s == 5'd31) return 32'd0;
`ifdef OPERAND_BYPASS_EN
        if (ex_wen && ex_waddr == s)   return ex_wdata;
        if (mem_wen && mem_waddr == s) return mem_wdata;
        if (wb_wen && wb_waddr == s)   return wb_wdata;
`endif
        return rf[s];
    endfunction

    // Reference: what the stage registers next, and whether it must stall now.
    task automatic model_eval(output exp_t nx, output bit est);
        kind_e       k;
        logic [4:0]  ra, rb, rc;
        logic [31:0] sx;
        logic [4:0]  used[$];
        bit          take;
        k  = kind_of(in_instr[31:26]);
        rc = in_instr[25:21];
        ra = in_instr[20:16];
        rb = in_instr[15:11];
        sx = 32'($signed(in_instr[15:0]));
        if (k != K_ILL) used.push_back(ra);
        if (k == K_OP)  used.push_back(rb);
        if (k == K_ST)  used.push_back(rc);
        est = 0;
        foreach (used[i]) if (used[i] != 5'd31) begin
`ifdef OPERAND_BYPASS_EN
            if (ex_is_load && ex_wen && ex_waddr == used[i]) est = 1;
`else
            if ((ex_wen && ex_waddr == used[i]) || (mem_wen && mem_waddr == used[i]) ||
                (wb_wen && wb_waddr == used[i])) est = 1;
`endif
        end
        est      = est && in_valid && rst_n;
        take     = in_valid && !flush && !est;
        nx.valid = take;
        nx.wen   = take && (k == K_OP || k == K_OPC || k == K_LD) && rc != 5'd31;
        nx.ld    = take && k == K_LD;
        nx.st    = take && k == K_ST;
        nx.ill   = take && k == K_ILL;
        nx.a     = (k == K_ILL) ? 32'd0 : val(ra);
        nx.b     = (k == K_ILL) ? 32'd0 : (k == K_OP) ? val(rb) : sx;
        nx.fn    = (k == K_OP || k == K_OPC) ? in_instr[29:26] : 4'd0;
        nx.rc    = rc;
        nx.sd    = val(rc);
    endtask

    task automatic cmp(input string tag);
        chk({tag, ":valid"}, 32'(alu.out_valid), 32'(e.valid));
        chk({tag, ":wen"},   32'(alu.out_wen), 32'(e.wen));
        chk({tag, ":ld"},    32'(alu.out_is_load), 32'(e.ld));
        chk({tag, ":st"},    32'(alu.out_is_store), 32'(e.st));
        chk({tag, ":ill"},   32'(alu.out_illegal), 32'(e.ill));
        if (e.valid) begin
            chk({tag, ":a"},  alu.data_a, e.a);
            chk({tag, ":b"},  alu.data_b, e.b);
            chk({tag, ":fn"}, 32'(alu.alufn), 32'(e.fn));
            chk({tag, ":rc"}, 32'(alu.out_rc), 32'(e.rc));
        end
        if (e.st) chk({tag, ":sd"}, alu.out_store_data, e.sd);
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic step(input string tag);
        exp_t nx;
        bit   est;
        logic [4:0] eb;
        #1;
        model_eval(nx, est);
        eb = (kind_of(in_instr[31:26]) == K_ST) ? in_instr[25:21] : in_instr[15:11];
        chk({tag, ":stall"}, 32'(stall), 32'(est));
        chk({tag, ":addr_a"}, 32'(rf_addr_a), 32'(in_instr[20:16]));
        chk({tag, ":addr_b"}, 32'(rf_addr_b), 32'(eb));
        @(posedge clk);
        if (clk_en) e = nx;
        #1;
        cmp(tag);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rc,
                                       input logic [4:0] ra, input logic [15:0] lo);
        return {op, rc, ra, lo};
    endfunction

    task automatic clear_haz();
        ex_wen = 0; mem_wen = 0; wb_wen = 0; ex_is_load = 0;
        ex_waddr = 0; mem_waddr = 0; wb_waddr = 0;
        ex_wdata = 0; mem_wdata = 0; wb_wdata = 0;
    endtask

    function automatic logic [4:0] pick();
        int r;
        r = $urandom_range(0, 9);
        return (r >= 8) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        rst_n = 0; clk_en = 1; flush = 0; in_valid = 0; in_instr = 0;
        clear_haz();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[31] = 32'hDEADBEEF;
        e = '{default: '0};
        #3;
        cmp("reset");
        chk("reset:a", alu.data_a, 32'd0);
        chk("reset:stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // ADDC R1,5,R2
        rf[1] = 32'd7;
        in_valid = 1;
        in_instr = mk(6'b110000, 5'd2, 5'd1, 16'd5);
        step("addc");
        chk("addc:a_k", alu.data_a, 32'd7);
        chk("addc:b_k", alu.data_b, 32'd5);
        chk("addc:rc_k", 32'(alu.out_rc), 32'd2);
        chk("addc:wen_k", 32'(alu.out_wen), 32'd1);

        // Async reset mid-cycle while out_valid=1 and a stall condition present
        ex_is_load = 1; ex_wen = 1; ex_waddr = 5'd1;
        #2 rst_n = 0;
        #1;
        e = '{default: '0};
        cmp("midrst");
        chk("midrst:a", alu.data_a, 32'd0);
        chk("midrst:b", alu.data_b, 32'd0);
        chk("midrst:stall", 32'(stall), 32'd0);
        #1 rst_n = 1;
        clear_haz();
        step("post_rst");
        chk("post_rst:v_k", 32'(alu.out_valid), 32'd1);

        // SUB R3,R4,R5 with forwarding candidates in all stages
        in_instr = mk(6'b100001, 5'd5, 5'd3, {5'd4, 11'd0});
        ex_wen = 1; ex_waddr = 5'd3; ex_wdata = 32'h10;
        mem_wen = 1; mem_waddr = 5'd3; mem_wdata = 32'h20;
        wb_wen = 1; wb_waddr = 5'd4; wb_wdata = 32'h30;
        step("sub");
`ifdef OPERAND_BYPASS_EN
        chk("sub:a_k", alu.data_a, 32'h10);
        chk("sub:b_k", alu.data_b, 32'h30);
        chk("sub:fn_k", 32'(alu.alufn), 32'd1);
`endif
        clear_haz();

        // Load-use: LD writing R7 in EX, ADD R7,R1,R2 presented
        ex_is_load = 1; ex_wen = 1; ex_waddr = 5'd7;
        in_instr = mk(6'b100000, 5'd2, 5'd7, {5'd1, 11'd0});
        step("ldu1");
        chk("ldu1:bubble_k", 32'(alu.out_valid), 32'd0);
        clear_haz();
        step("ldu2");
        chk("ldu2:issue_k", 32'(alu.out_valid), 32'd1);

        // ST R9,-4(R31) with R9 pending in WB
        wb_wen = 1; wb_waddr = 5'd9; wb_wdata = 32'hABCD;
        in_instr = mk(6'b011001, 5'd9, 5'd31, 16'hFFFC);
        step("st");
`ifdef OPERAND_BYPASS_EN
        chk("st:a_k", alu.data_a, 32'd0);
        chk("st:b_k", alu.data_b, 32'hFFFFFFFC);
        chk("st:sd_k", alu.out_store_data, 32'hABCD);
        chk("st:wen_k", 32'(alu.out_wen), 32'd0);
`endif
        clear_haz();

        // Illegal opcode
        in_instr = mk(6'b000000, 5'd3, 5'd1, 16'h1234);
        step("ill");
        chk("ill:ill_k", 32'(alu.out_illegal), 32'd1);
        chk("ill:wen_k", 32'(alu.out_wen), 32'd0);

        // Flush of a valid ADD
        in_instr = mk(6'b100000, 5'd2, 5'd1, {5'd3, 11'd0});
        step("pre_flush");
        flush = 1;
        step("flush");
        chk("flush:v_k", 32'(alu.out_valid), 32'd0);
        flush = 0;

        // Hold with clk_en=0
        step("pre_hold");
        clk_en = 0;
        in_instr = mk(6'b110010, 5'd4, 5'd5, 16'h8001);
        step("hold");
        chk("hold:v_k", 32'(alu.out_valid), 32'd1);
        clk_en = 1;

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            logic [5:0]  op;
            logic [15:0] lo;
            int          r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: op = {2'b10, 4'($urandom)};
                3, 4:    op = {2'b11, 4'($urandom)};
                5:       op = 6'b011000;
                6:       op = 6'b011001;
                default: op = 6'($urandom);
            endcase
            lo = 16'($urandom);
            if (op[5:4] == 2'b10) lo[15:11] = pick();
            in_instr  = mk(op, pick(), pick(), lo);
            in_valid  = ($urandom_range(0, 99) < 85);
            flush     = ($urandom_range(0, 99) < 10);
            clk_en    = ($urandom_range(0, 99) < 90);
            ex_wen    = $urandom_range(0, 1) == 1; ex_waddr  = pick(); ex_wdata  = $urandom;
            mem_wen   = $urandom_range(0, 1) == 1; mem_waddr = pick(); mem_wdata = $urandom;
            wb_wen    = $urandom_range(0, 1) == 1; wb_waddr  = pick(); wb_wdata  = $urandom;
            ex_is_load = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 31)] = $urandom;
            step($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
